// File: rtl/sumram_drain_pkg.sv
// sumram_drain_pkg: shared FSM encoding and FIFO sizing for the accumulation RAM drain engine
package sumram_drain_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;
  function automatic int fifo_depth(input int ram_lat);
    return ram_lat + 2;
  endfunction
endpackage

// File: rtl/drain_fifo.sv
// drain_fifo: synchronous register FIFO with occupancy count, non power-of-two depth allowed
module drain_fifo
  import sumram_drain_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = fifo_depth(2),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = din;
    wp_d = !push ? wp_q : wp_q == PW'(DEPTH - 1) ? '0 : wp_q + 1'b1;
    rp_d = !pop ? rp_q : rp_q == PW'(DEPTH - 1) ? '0 : rp_q + 1'b1;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rp_q];
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(DEPTH);
  assign count = cnt_q;
endmodule

// File: rtl/sumram_drain.sv
// sumram_drain: streams a block of accumulation RAM words out in address order under credit flow control
module sumram_drain
  import sumram_drain_pkg::*;
#(
  parameter int C_DSIZE   = 32,
  parameter int C_ASIZE   = 10,
  parameter int C_LENSIZE = 9,
  parameter int C_RAM_LAT = 2
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_start,
  input  logic [C_ASIZE-1:0]   I_base,
  input  logic [C_LENSIZE-1:0] I_len,
  output logic [C_ASIZE-1:0]   O_raddr,
  output logic                 O_rd,
  input  logic [C_DSIZE-1:0]   I_rdata,
  output logic [C_DSIZE-1:0]   O_dout,
  output logic                 O_dv,
  input  logic                 I_ready,
  output logic                 O_busy,
  output logic                 O_done
);
  localparam int D  = fifo_depth(C_RAM_LAT);
  localparam int CW = $clog2(D + 1);
  state_e state_q, state_d;
  logic [C_ASIZE-1:0] base_q, base_d, raddr_q, raddr_d;
  logic [C_LENSIZE-1:0] len_q, len_d;
  logic [C_LENSIZE:0] iss_q, iss_d, xfer_q, xfer_d;
  logic [C_RAM_LAT-1:0] vld_q, vld_d;
  logic rd_q, rd_d, busy_q, busy_d, done_q, done_d;
  logic push, pop, empty, full, credit;
  logic [CW-1:0] cnt;
  assign push = vld_q[C_RAM_LAT-1];
  assign pop = !empty && I_ready;
  assign credit = int'(rd_q) + $countones(vld_q) + int'(cnt) - int'(pop) < D;
  drain_fifo #(.DW(C_DSIZE), .DEPTH(D), .CW(CW)) u_fifo (
    .clk(I_clk), .rst(I_rst), .push(push), .pop(pop), .din(I_rdata),
    .dout(O_dout), .full(full), .empty(empty), .count(cnt)
  );
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    len_d = len_q;
    iss_d = iss_q;
    xfer_d = xfer_q + (C_LENSIZE + 1)'(pop);
    raddr_d = raddr_q;
    rd_d = 1'b0;
    vld_d = (vld_q << 1) | C_RAM_LAT'(rd_q);
    unique case (state_q)
      S_IDLE: if (I_start) begin
        base_d = I_base;
        len_d = I_len;
        iss_d = '0;
        xfer_d = '0;
        state_d = I_len == '0 ? S_DONE : S_RUN;
      end
      S_RUN: if (credit) begin
        rd_d = 1'b1;
        raddr_d = base_q + C_ASIZE'(iss_q);
        iss_d = iss_q + 1'b1;
        state_d = iss_d == {1'b0, len_q} ? S_FLUSH : S_RUN;
      end
      S_FLUSH: state_d = xfer_d == {1'b0, len_q} ? S_DONE : S_FLUSH;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d == S_RUN || state_d == S_FLUSH;
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= S_IDLE;
      base_q <= '0;
      len_q <= '0;
      iss_q <= '0;
      xfer_q <= '0;
      raddr_q <= '0;
      rd_q <= 1'b0;
      vld_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      len_q <= len_d;
      iss_q <= iss_d;
      xfer_q <= xfer_d;
      raddr_q <= raddr_d;
      rd_q <= rd_d;
      vld_q <= vld_d;
      busy_q <= busy_d;
      done_q <= done_d;
      assert (!(push && full && !pop));
    end
  end
  assign O_raddr = raddr_q;
  assign O_rd = rd_q;
  assign O_dv = !empty;
  assign O_busy = busy_q;
  assign O_done = done_q;
endmodule

// File: tb/tb_sumram_drain.sv
// tb_sumram_drain: randomized drain passes checked against a queue-based model of the expected word stream
module tb_sumram_drain;
  localparam int DW = 32, AW = 10, LW = 9, LAT = 2, D = LAT + 2;
  logic clk = 1'b0, rst, start, ready;
  logic [AW-1:0] base, raddr;
  logic [LW-1:0] len;
  logic [DW-1:0] rdata, dout;
  logic rd, dv, busy, done;
  logic [DW-1:0] ram [1 << AW];
  logic [DW-1:0] pipe [LAT];
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  logic [DW-1:0] dout_prev;
  bit stall_prev;
  int checks = 0, errors = 0, cyc = 0, rmode = 0;
  int issued = 0, xfer = 0, done_cnt = 0, first_rd = -1, last_rd = -1, first_dv = -1;
  int last_x = -1, done_cyc = -1, start_cyc = -1, max_out = 0;
  always #5 clk = ~clk;
  sumram_drain #(.C_DSIZE(DW), .C_ASIZE(AW), .C_LENSIZE(LW), .C_RAM_LAT(LAT)) dut (
    .I_clk(clk), .I_rst(rst), .I_start(start), .I_base(base), .I_len(len),
    .O_raddr(raddr), .O_rd(rd), .I_rdata(rdata), .O_dout(dout), .O_dv(dv),
    .I_ready(ready), .O_busy(busy), .O_done(done)
  );
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= rd ? ram[raddr] : $urandom;
  end
  assign rdata = pipe[LAT-1];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  initial begin
    int ph;
    ph = 0;
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      ready = rmode == 0 ? 1'b1 : rmode == 1 ? (ph % 4 == 0) : 1'($urandom_range(0, 1));
    end
  end
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) stall_prev = 1'b0;
    else begin
      if (start && start_cyc < 0) start_cyc = cyc;
      if (rd) begin
        issued++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        if (exp_addr.size() == 0) chk("rd_extra", 1, 0);
        else chk("raddr", raddr, exp_addr.pop_front());
        if (issued - xfer > max_out) max_out = issued - xfer;
        chk("credit", issued - xfer <= D, 1);
      end
      if (stall_prev) begin
        chk("hold_dv", dv, 1);
        chk("hold_dout", dout, dout_prev);
      end
      if (dv && first_dv < 0) first_dv = cyc;
      if (dv && ready) begin
        xfer++;
        last_x = cyc;
        if (exp_data.size() == 0) chk("dv_extra", 1, 0);
        else chk("dout", dout, exp_data.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_busy", busy, 0);
      end
      stall_prev = dv && !ready;
      dout_prev = dout;
    end
  end
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_addr.delete();
    exp_data.delete();
  endtask
  task automatic run_pass(input logic [AW-1:0] b, input int l, input int mode, input bit spam, input int abort_at);
    logic [AW-1:0] a;
    exp_addr.delete();
    exp_data.delete();
    for (int k = 0; k < l; k++) begin
      a = b + AW'(k);
      exp_addr.push_back(a);
      exp_data.push_back(ram[a]);
    end
    issued = 0; xfer = 0; done_cnt = 0; first_rd = -1; last_rd = -1; first_dv = -1;
    last_x = -1; done_cyc = -1; start_cyc = -1; max_out = 0; rmode = mode;
    @(posedge clk);
    #1 start = 1'b1; base = b; len = LW'(l);
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, l != 0);
    for (int n = 0; n < 50 + 8 * l && done_cnt == 0; n++) begin
      if (spam && n == 3) begin start = 1'b1; base = ~b; len = LW'(l + 5); end
      if (spam && n == 4) start = 1'b0;
      if (abort_at > 0 && issued >= abort_at) begin
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_raddr", raddr, 0);
        chk("abort_rd", rd, 0);
        chk("abort_dout", dout, 0);
        chk("abort_dv", dv, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < LAT + 3; i++) begin
          @(posedge clk);
          #1 chk("stale_dv", dv, 0);
        end
        chk("abort_no_done", done_cnt, 0);
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("done_seen", done_cnt, 1);
    chk("xfer_count", xfer, l);
    chk("read_count", issued, l);
    chk("leftover", exp_data.size(), 0);
    @(posedge clk);
    #1 chk("done_one_cycle", done, 0);
    if (l == 0) begin
      chk("len0_done_lat", done_cyc - start_cyc, 1);
      chk("len0_no_dv", first_dv, -1);
    end else chk("done_after_last", done_cyc - last_x, 1);
    if (mode == 0 && l > 0) begin
      chk("first_dv_lat", first_dv - first_rd, LAT + 1);
      chk("reads_b2b", last_rd - first_rd, l - 1);
      chk("xfers_b2b", done_cyc - first_dv, l);
    end
    if (mode == 1 && l >= D) chk("credit_full", max_out, D);
    if (done_cnt == 0) do_reset();
  endtask
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
    rst = 1'b1; start = 1'b1; base = '0; len = LW'(5);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_raddr", raddr, 0);
    chk("rst_rd", rd, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dv", dv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_reads", issued, 0);
    run_pass(10'h010, 8, 0, 1'b0, 0);
    run_pass(10'h3FE, 4, 0, 1'b0, 0);
    run_pass(AW'($urandom), 16, 1, 1'b0, 0);
    run_pass(AW'($urandom), 0, 0, 1'b0, 0);
    run_pass(AW'($urandom), 10, 0, 1'b0, 3);
    run_pass('0, 2, 0, 1'b0, 0);
    run_pass(AW'($urandom), 12, 0, 1'b1, 0);
    for (int p = 0; p < 8; p++) run_pass(AW'($urandom), $urandom_range(1, 40), 2, 1'b0, 0);
    run_pass(AW'($urandom), (1 << LW) - 1, 0, 1'b0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sumram_drain.md
SUMRAM_DRAIN -- requirements
Module: sumram_drain

Interface
REQ-001 Parameter C_DSIZE, default 32, data word width (matches accumulation RAM).
REQ-002 Parameter C_ASIZE, default 10, RAM address width.
REQ-003 Parameter C_LENSIZE, default 9, word-count width.
REQ-004 Parameter C_RAM_LAT, default 2, cycles from O_rd to valid I_rdata (1..4).
REQ-005 I_clk  in  1  single clock; all logic rising-edge.
REQ-006 I_rst  in  1  reset, synchronous, active-high.
REQ-007 I_start  in  1  one-cycle pulse starting a drain pass.
REQ-008 I_base  in  C_ASIZE  first RAM address of the pass, sampled on accepted I_start.
REQ-009 I_len  in  C_LENSIZE  number of words to drain, sampled on accepted I_start.
REQ-010 O_raddr  out  C_ASIZE  RAM read address.
REQ-011 O_rd  out  1  RAM read enable.
REQ-012 I_rdata  in  C_DSIZE  RAM read data, valid C_RAM_LAT cycles after O_rd.
REQ-013 O_dout  out  C_DSIZE  output stream data.
REQ-014 O_dv  out  1  output word valid.
REQ-015 I_ready  in  1  downstream accept; transfer when O_dv and I_ready both high.
REQ-016 O_busy  out  1  high from accepted start until O_done.
REQ-017 O_done  out  1  one-cycle pulse after last word transferred.

Function
REQ-018 FSM states IDLE, RUN, FLUSH, DONE; reset state IDLE.
REQ-019 IDLE: I_start accepted -> latch I_base/I_len; I_len=0 -> DONE, else RUN; O_busy high from next cycle.
REQ-020 I_start during RUN/FLUSH/DONE ignored, latched values unchanged.
REQ-021 RUN: issue one read per cycle when credit available; address I_base+k for k=0..len-1, modulo 2^C_ASIZE (wrap from max address to 0).
REQ-022 Credit rule: O_rd only when (in-flight reads + FIFO occupancy) < FIFO depth; FIFO depth = C_RAM_LAT+2; no word ever dropped.
REQ-023 In-flight tracking by C_RAM_LAT-deep valid shift register; I_rdata captured into FIFO only when shift register output high.
REQ-024 RUN -> FLUSH in cycle issuing read k=len-1.
REQ-025 FLUSH: no reads; -> DONE when in-flight=0, FIFO empty, len words transferred.
REQ-026 DONE: O_done=1 for exactly one cycle, O_busy=0 in same cycle, -> IDLE; I_start accepted again in that IDLE cycle.
REQ-027 O_dv = FIFO not empty; O_dout = FIFO head; O_dout/O_dv held stable while O_dv && !I_ready.
REQ-028 Words emitted in address order; exactly I_len transfers per pass.
REQ-029 I_ready held high continuously: throughput one word/cycle after initial latency of C_RAM_LAT+1 cycles from first O_rd to first O_dv.
REQ-030 O_raddr holds last value when O_rd low; no constraint on value.
REQ-031 Simultaneous FIFO push and pop: occupancy unchanged, both take effect.
REQ-032 Transfer counter width C_LENSIZE+1; I_len = 2^C_LENSIZE-1 drains fully without overflow.

Reset
REQ-033 I_rst high: FSM->IDLE, FIFO emptied, in-flight shift register cleared, counters 0.
REQ-034 Output reset values: O_raddr=0, O_rd=0, O_dout=0, O_dv=0, O_busy=0, O_done=0.
REQ-035 Reset mid-pass: read data returning after reset never enters FIFO; no O_done for aborted pass.
REQ-036 I_start coincident with I_rst ignored.

Structure
REQ-037 Shared package holds FSM state encoding (IDLE/RUN/FLUSH/DONE) and FIFO-depth function of C_RAM_LAT.
REQ-038 One sub-module: drain_fifo, synchronous register FIFO (push, pop, full, empty, count), same reset.
REQ-039 RAM instance external; block drives read port only, never write port.

Verification
REQ-040 base=0x010, len=8, I_ready=1, C_RAM_LAT=2 -> reads 0x010..0x017 consecutive, first O_dv 3 cycles after first O_rd, 8 transfers back-to-back, O_done next cycle after last.
REQ-041 base=0x3FE, len=4 -> addresses 0x3FE,0x3FF,0x000,0x001; data out in that order.
REQ-042 len=16, I_ready toggling 1-cycle high/3-cycle low -> 16 words in order, none lost or duplicated, O_dout stable while stalled, O_rd pauses when FIFO+in-flight=4.
REQ-043 len=0 -> no O_rd, O_done pulse 1 cycle after start, no O_dv.
REQ-044 I_rst asserted 2 cycles after third O_rd of len=10 pass -> all outputs 0 next cycle, no O_dv from stale data; new pass base=0, len=2 completes correctly.
REQ-045 I_start repeated during RUN with different base/len -> ignored; original pass completes unchanged.
